mult_result_spi_tx: RTL
=======================

// Module: mult_result_spi_tx
// PURPOSE
//  Downstream stage of the sequential multiplier. Captures the 2*width result on the
//  multiplier's one-cycle done pulse and holds up to two results (shift reg + one pending).
//  Serializes each result MSB-first onto SPI MISO (mode 0) for an external master.
//  Oversamples the master's sclk/cs_n in the clk domain.
// PARAMETERS
//  width        4  multiplier operand width; result and frame length are 2*width bits
//  SYNC_STAGES  2  flops in each sclk/cs_n synchronizer, minimum 2
// PORTS
//  clk        in   1        system clock, all state updates on posedge
//  rst_n      in   1        asynchronous active-low reset
//  res        in   2*width  multiplier result, valid only while done=1
//  done       in   1        one-cycle pulse from multiplier: res is valid
//  sclk       in   1        SPI clock from master, async to clk
//  cs_n       in   1        SPI chip select from master, active low, async
//  miso       out  1        serial data, MSB first
//  miso_oe    out  1        1 = drive miso (cs_n sync low); 0 = tri-state at pad
//  tx_ready   out  1        1 = a result is loaded and waiting for a frame
//  pending    out  1        1 = second result queued behind the current one
//  overrun    out  1        sticky: a result was dropped; cleared only by rst_n
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; shift reg, pending reg and bit counter = 0.
//   Outputs: miso=0, miso_oe=0, tx_ready=0, pending=0, overrun=0.
//   Synchronizers reset to sclk=0, cs_n=1.
//  Sync: sclk_s/cs_n_s = SYNC_STAGES-flop sync plus one history flop for edge detect.
//   sclk_rise, sclk_fall and cs_fall are one-cycle pulses.
//   Pin-to-internal latency = SYNC_STAGES+1 clk. Master sclk half-period must be >= 4 clk.
//  States (encodings in shared header):
//   IDLE: nothing held. done=1 loads res -> LOADED, next cycle.
//   LOADED: tx_ready=1; miso = shreg[2*width-1].
//     cs_fall -> SHIFT, bit counter = 0.
//   SHIFT: on each sclk_fall: shreg <= {shreg[2*width-2:0],1'b0}, count++.
//     The first bit is presented before the first sclk_rise.
//     count reaches 2*width-1 and sclk_fall occurs -> DRAIN.
//   DRAIN: miso=0; wait for cs_n_s=1.
//     Then go to LOADED if pending=1 (pending reg moves into shreg, pending=0), else IDLE.
//  tx_ready=1 only in LOADED. miso_oe = ~cs_n_s in every state. miso=0 in IDLE and DRAIN.
//  done while LOADED, SHIFT or DRAIN:
//   - pending=0: res goes into the pending reg, pending=1.
//   - pending=1: new res is dropped, overrun=1; the existing pending value is kept.
//  cs_n_s rises mid-frame (SHIFT, count < 2*width-1): frame aborted, current result discarded.
//   Same exit as DRAIN (pending -> LOADED, else IDLE). overrun is not set.
//  cs_fall while IDLE: miso_oe=1, miso=0, no state change. The master reads all zeros.
//   A done arriving later in that frame is not shifted out until the next cs_fall.
//  Simultaneous done and pending->shreg transfer in the same cycle:
//   the transfer happens first, and the new res lands in the now-empty pending reg. No overrun.
//  Simultaneous done and cs_fall in IDLE: res loads, state goes to LOADED.
//   cs_fall is consumed only in LOADED, so this frame is not started.
//   The master must reassert cs_n to read the result.
//  Width rules: shreg and pending reg are 2*width bits; counter is $clog2(2*width) bits.
//   No arithmetic on data.
//  rst_n assertion mid-frame: immediate return to reset values; all held results are lost.
// STRUCTURE
//  Shared header mult_spi_defines.v holds:
//   - state localparams: IDLE=2'b00, LOADED=2'b01, SHIFT=2'b10, DRAIN=2'b11
//   - SPI mode constant (mode 0)
//  The shift register reuses the existing shiftregister module with
//   PLOAD/LEFT/HOLD modes from shiftregmodes.v, width = 2*width.
//  One natural sub-module: spi_pin_sync.
//   Parameterized SYNC_STAGES synchronizer plus rise/fall edge detector.
//   Instantiated once for sclk and once for cs_n.
// TESTING
//  All scenarios use width=4, sclk period = 10 clk.
//  1. Multiplier 13*11: done with res=8'h8F, then one 8-bit frame.
//     -> miso samples on sclk rise = 1,0,0,0,1,1,1,1; tx_ready 1->0 at cs_fall; IDLE after cs_n high.
//  2. done res=8'h12, done res=8'h34 during frame 1, done res=8'h56 during frame 1.
//     -> frame1=8'h12, frame2=8'h34, 8'h56 dropped; overrun=1 and stays 1.
//  3. done res=8'hA5; cs_n raised after 3 sclk.
//     -> frame aborted, state IDLE, next frame reads 8'h00, overrun=0.
//  4. rst_n pulsed low for 1 clk mid-frame with pending=1.
//     -> all outputs 0 asynchronously, pending=0, tx_ready=0; next done loads normally.
//  5. done on the same clk as pending->shreg transfer (pending=1 in DRAIN, cs_n rises).
//     -> transferred value transmits next; new res held in pending, overrun=0.
//  6. cs_n low with nothing loaded.
//     -> miso_oe=1, miso=0 for all 8 bits; a done mid-frame sets tx_ready=1 without corrupting the frame.

Source files
------------

// File: rtl/mult_result_spi_tx_pkg.sv
// Shared types for the multiplier-result SPI transmitter: FSM states, shift-register modes
// and the SPI mode constant.
package mult_result_spi_tx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLoaded = 2'b01,
    StShift  = 2'b10,
    StDrain  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ShHold  = 2'b00,
    ShPload = 2'b01,
    ShLeft  = 2'b10
  } sh_mode_e;

  localparam int unsigned SpiMode = 0;

endpackage

// File: rtl/mult_result_spi_tx_if.sv
// Bus between the multiplier / SPI master side and the result transmitter.
interface mult_result_spi_tx_if #(
  parameter int unsigned width = 4
);
  logic [2*width-1:0] res;
  logic               done;
  logic               sclk;
  logic               cs_n;
  logic               miso;
  logic               miso_oe;
  logic               tx_ready;
  logic               pending;
  logic               overrun;

  modport master (
    output res, done, sclk, cs_n,
    input  miso, miso_oe, tx_ready, pending, overrun
  );

  modport slave (
    input  res, done, sclk, cs_n,
    output miso, miso_oe, tx_ready, pending, overrun
  );
endinterface

// File: rtl/mult_result_spi_tx_spi_pin_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin plus a history flop for edge pulses.
module mult_result_spi_tx_spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ResetVal    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/mult_result_spi_tx.sv
// Captures multiplier results (one in the shift register, one pending) and shifts them out
// MSB-first as an SPI mode-0 slave, oversampling sclk/cs_n in the clk domain.
module mult_result_spi_tx
  import mult_result_spi_tx_pkg::*;
#(
  parameter int unsigned width       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_result_spi_tx_if.slave bus
);

  localparam int unsigned ResW = 2 * width;
  localparam int unsigned CntW = $clog2(ResW);
  localparam logic [CntW-1:0] LastBit = CntW'(ResW - 1);

  state_e          state_q, state_d;
  sh_mode_e        sh_mode;
  logic [ResW-1:0] sh_din, shreg_q;
  logic [ResW-1:0] pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic            overrun_q, overrun_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            leave;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic unused_edges;

  mult_result_spi_tx_spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ResetVal   (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (bus.sclk),
    .level_o(sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  mult_result_spi_tx_spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ResetVal   (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (bus.cs_n),
    .level_o(cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign unused_edges = sclk_s ^ sclk_rise ^ cs_rise;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_d    = overrun_q;
    sh_mode      = ShHold;
    sh_din       = pend_q;
    leave        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.done) begin
          sh_mode = ShPload;
          sh_din  = bus.res;
          state_d = StLoaded;
        end
      end
      StLoaded: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (cs_n_s) begin
          leave = 1'b1;
        end else if (sclk_fall) begin
          sh_mode = ShLeft;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBit) state_d = StDrain;
        end
      end
      StDrain: begin
        if (cs_n_s) leave = 1'b1;
      end
    endcase

    // Frame end or abort: promote the pending result, else clear the shifter and idle.
    if (leave) begin
      sh_mode = ShPload;
      if (pend_valid_q) begin
        sh_din       = pend_q;
        pend_valid_d = 1'b0;
        state_d      = StLoaded;
      end else begin
        sh_din  = '0;
        state_d = StIdle;
      end
    end

    // Evaluated after the promotion so a same-cycle done lands in the freed pending slot.
    if (bus.done && (state_q != StIdle)) begin
      if (!pend_valid_d) begin
        pend_d       = bus.res;
        pend_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      unique case (sh_mode)
        ShPload: shreg_q <= sh_din;
        ShLeft:  shreg_q <= {shreg_q[ResW-2:0], 1'b0};
        default: shreg_q <= shreg_q;
      endcase
    end
  end

  // In LOADED the MSB is only presented while deselected, so a result that arrives in
  // the middle of someone else's frame cannot disturb the zeros that frame is reading.
  assign bus.miso     = (state_q == StShift || (state_q == StLoaded && cs_n_s)) ?
                        shreg_q[ResW-1] : 1'b0;
  assign bus.miso_oe  = ~cs_n_s;
  assign bus.tx_ready = (state_q == StLoaded);
  assign bus.pending  = pend_valid_q;
  assign bus.overrun  = overrun_q;

endmodule
